// File: rtl/find_freq_peak.sv
// Peak-bin search over the FFT magnitude memory, mapped to the nearest guitar string.
// Optional FIND_FREQ_THRESHOLD_EN reports "no note" for peaks below MIN_MAG.
module find_freq_peak #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 10,
    parameter int START_BIN = 1,
    parameter int END_BIN   = 1023,
    parameter int TGT0      = 42,
    parameter int TGT1      = 56,
    parameter int TGT2      = 75,
    parameter int TGT3      = 100,
    parameter int TGT4      = 126,
    parameter int TGT5      = 169,
    parameter int MIN_MAG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              did_find,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic signed [9:0] difference,
    output logic [2:0]        note
);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, MAP, DONE} state_t;

    localparam int DW = ADDR_W + 2;
    localparam logic signed [DW-1:0] SAT_HI = DW'(511);
    localparam logic signed [DW-1:0] SAT_LO = DW'(-512);
`ifdef FIND_FREQ_THRESHOLD_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rd_bin_q, rd_bin_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   peak_mag_q, peak_mag_d;
    logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
    logic [2:0]          note_q, note_d;
    logic signed [9:0]   diff_q, diff_d;
    logic                did_find_q, did_find_d;

    logic [2:0]          best_i;
    logic signed [DW-1:0] best_diff, best_dist, cur_diff, cur_dist;
    logic signed [9:0]   sat_diff;

    function automatic logic signed [DW-1:0] tgt(input int i);
        case (i)
            0:       tgt = DW'(TGT0);
            1:       tgt = DW'(TGT1);
            2:       tgt = DW'(TGT2);
            3:       tgt = DW'(TGT3);
            4:       tgt = DW'(TGT4);
            default: tgt = DW'(TGT5);
        endcase
    endfunction

    // Strict '<' keeps the lower string index when two targets are equidistant.
    always_comb begin
        best_i    = 3'd0;
        best_diff = signed'({2'b00, peak_bin_q}) - tgt(0);
        best_dist = best_diff[DW-1] ? -best_diff : best_diff;
        cur_diff  = '0;
        cur_dist  = '0;
        for (int i = 1; i < 6; i++) begin
            cur_diff = signed'({2'b00, peak_bin_q}) - tgt(i);
            cur_dist = cur_diff[DW-1] ? -cur_diff : cur_diff;
            if (cur_dist < best_dist) begin
                best_i    = 3'(i);
                best_diff = cur_diff;
                best_dist = cur_dist;
            end
        end
        if (best_diff > SAT_HI)
            sat_diff = 10'sd511;
        else if (best_diff < SAT_LO)
            sat_diff = -10'sd512;
        else
            sat_diff = best_diff[9:0];
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_bin_d   = rd_bin_q;
        rd_valid_d = 1'b0;
        peak_mag_d = peak_mag_q;
        peak_bin_d = peak_bin_q;
        note_d     = note_q;
        diff_d     = diff_q;
        did_find_d = 1'b0;

        // data_in always belongs to the address issued one cycle earlier.
        if ((state_q == SCAN || state_q == DRAIN) && rd_valid_q
            && data_in > peak_mag_q) begin
            peak_mag_d = data_in;
            peak_bin_d = rd_bin_q;
        end

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (enable) begin
                    addr_d     = ADDR_W'(START_BIN);
                    peak_mag_d = '0;
                    peak_bin_d = ADDR_W'(START_BIN);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                rd_valid_d = 1'b1;
                rd_bin_d   = addr_q;
                if (!enable) begin
                    addr_d  = '0;
                    state_d = IDLE;
                end else if (addr_q == ADDR_W'(END_BIN)) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                addr_d  = '0;
                state_d = enable ? MAP : IDLE;
            end
            MAP: begin
                addr_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    if (THR_EN && peak_mag_q < DATA_W'(MIN_MAG)) begin
                        note_d = 3'd7;
                        diff_d = '0;
                    end else begin
                        note_d = best_i;
                        diff_d = sat_diff;
                    end
                    did_find_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                addr_d = '0;
                if (enable) did_find_d = 1'b1;
                else        state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_bin_q   <= '0;
            rd_valid_q <= 1'b0;
            peak_mag_q <= '0;
            peak_bin_q <= '0;
            note_q     <= 3'd7;
            diff_q     <= '0;
            did_find_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_bin_q   <= rd_bin_d;
            rd_valid_q <= rd_valid_d;
            peak_mag_q <= peak_mag_d;
            peak_bin_q <= peak_bin_d;
            note_q     <= note_d;
            diff_q     <= diff_d;
            did_find_q <= did_find_d;
        end
    end

    assign did_find   = did_find_q;
    assign mem_addr   = addr_q;
    assign note       = note_q;
    assign difference = diff_q;

endmodule

// File: tb/tb_find_freq_peak.sv
// Scoreboard bench for find_freq_peak: directed spectra, queued expected results.
module tb_find_freq_peak;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              did_find;
    logic [10:0]       mem_addr;
    logic [9:0]        data_in;
    logic signed [9:0] difference;
    logic [2:0]        note;

    logic [9:0]  mem [2048];
    logic [12:0] exp_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        df_prev = 1'b0;

    find_freq_peak dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .did_find   (did_find),
        .mem_addr   (mem_addr),
        .data_in    (data_in),
        .difference (difference),
        .note       (note)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_in <= mem[mem_addr];

    // Monitor: compare each fresh result against the oldest queued expectation.
    always @(negedge clk) begin
        logic [12:0] e;
        if (did_find && !df_prev && !rst) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_result note=%0d diff=%0d required=none",
                         note, difference);
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (note !== e[12:10]) begin
                    n_bad++;
                    $display("FAIL note got=%0d required=%0d", note, e[12:10]);
                end
                n_vec++;
                if (difference !== $signed(e[9:0])) begin
                    n_bad++;
                    $display("FAIL difference got=%0d required=%0d",
                             difference, $signed(e[9:0]));
                end
            end
        end
        if (mem_addr > 11'd1023) begin
            n_bad++;
            $display("FAIL mem_addr_range got=%0d required<=1023", mem_addr);
        end
        df_prev = did_find;
    end

    task automatic check(input string nm, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s got=%0d required=%0d", nm, got, req);
        end
    endtask

    task automatic fill(input logic [9:0] base);
        for (int i = 0; i < 2048; i++) mem[i] = base;
    endtask

    task automatic run(input logic [2:0] n, input int d);
        int   cnt;
        logic got;
        logic signed [9:0] d10;
        d10 = 10'(d);
        exp_q.push_back({n, d10});
        enable = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 1200) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            got = did_find;
        end
        check("latency", got ? cnt : -1, 1026);
        if (got) begin
            repeat (4) @(negedge clk);
            check("did_find_hold", int'(did_find), 1);
            enable = 1'b0;
            @(negedge clk);
            check("did_find_release", int'(did_find), 0);
        end else begin
            void'(exp_q.pop_back());
            enable = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        fill(10'd5);
        repeat (3) @(negedge clk);
        check("rst_note", int'(note), 7);
        check("rst_diff", int'(difference), 0);
        check("rst_did_find", int'(did_find), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        mem[100] = 10'd900;
        run(3'd3, 0);

        // Abort mid-scan: outputs keep the previous result.
        fill(10'd5);
        mem[130] = 10'd700;
        enable = 1'b1;
        repeat (500) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_did_find", int'(did_find), 0);
        check("abort_mem_addr", int'(mem_addr), 0);
        check("abort_note", int'(note), 3);
        check("abort_diff", int'(difference), 0);
        repeat (2) @(negedge clk);
        run(3'd4, 4);

        fill(10'd5); mem[91] = 10'd600;
        run(3'd3, -9);

        fill(10'd5); mem[60] = 10'd800; mem[200] = 10'd800;
        run(3'd1, 4);

        fill(10'd5); mem[80] = 10'd300;
        run(3'd2, 5);

        fill(10'd5); mem[49] = 10'd500;
        run(3'd0, 7);

        fill(10'd5); mem[1023] = 10'd900;
        run(3'd5, 511);

        // Asynchronous reset in the middle of a scan.
        fill(10'd5); mem[100] = 10'd900;
        enable = 1'b1;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_note", int'(note), 7);
        check("midrst_diff", int'(difference), 0);
        check("midrst_did_find", int'(did_find), 0);
        check("midrst_mem_addr", int'(mem_addr), 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fill(10'd10);
`ifdef FIND_FREQ_THRESHOLD_EN
        run(3'd7, 0);
`else
        run(3'd0, -41);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/find_freq_peak.md
Name: find_freq_peak

Overview:
- Scans the FFT magnitude spectrum held in the shared 2048x10 sample memory and locates the peak bin.
- Maps the peak to the nearest of six guitar-string target bins.
- Reports the note code and the signed bin offset from that target.
- Sits after the fft stage and feeds display_result; the top-level FSM runs it through an enable/done level handshake.

Parameters:
- ADDR_W, 11, memory address width.
- DATA_W, 10, magnitude word width; unsigned.
- START_BIN, 1, first bin scanned (skips DC).
- END_BIN, 1023, last bin scanned inclusive; END_BIN >= START_BIN.
- TGT0..TGT5, 42/56/75/100/126/169, target bins for E2/A2/D3/G3/B3/E4 (2048-pt FFT, ~1.953 Hz/bin); strictly ascending.
- MIN_MAG, 16, minimum peak magnitude for a valid detection (optional feature only).

Ports:
- clk, in, 1, system clock; all logic rising-edge.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, level request from top FSM.
- did_find, out, 1, result-ready level.
- mem_addr, out, ADDR_W, memory read address.
- data_in, in, DATA_W, memory read data; synchronous read, valid one cycle after mem_addr.
- difference, out, signed 10, peak_bin minus target bin of reported note.
- note, out, 3, 0..5 = E2,A2,D3,G3,B3,E4; 7 = no note; 6 unused.

Behaviour:
- Reset values: did_find=0, mem_addr=0, difference=0, note=7, FSM=IDLE, peak_mag=0, peak_bin=0.
- FSM states: IDLE, SCAN, DRAIN, MAP, DONE.
- IDLE:
  - mem_addr=0.
  - On enable=1: load mem_addr=START_BIN, clear peak_mag/peak_bin, go SCAN.
- SCAN:
  - mem_addr increments by 1 each cycle.
  - Each cycle, data_in (belonging to the previous address) is compared.
  - After END_BIN is issued, go DRAIN.
- DRAIN: compares the last word (END_BIN), then go MAP.
- Compare rule:
  - Update peak only if data_in > peak_mag (strictly greater).
  - Equal magnitudes therefore keep the lowest bin.
- MAP (one cycle):
  - note = index i minimizing |peak_bin - TGTi|; a tie picks the lower i.
  - difference = peak_bin - TGTnote, computed at 11+ bits, saturated to [-512, 511].
  - Go DONE.
- DONE:
  - did_find=1 while enable stays 1.
  - When enable=0: did_find=0 next cycle, go IDLE.
- Latency: enable high to did_find high = (END_BIN-START_BIN+1) + 3 cycles; 1026 cycles at defaults.
- enable dropping during SCAN/DRAIN/MAP: abort to IDLE next cycle; note/difference keep their previous values; did_find stays 0.
- note/difference change only in MAP and otherwise hold the last result.
- All-zero spectrum: peak_bin = START_BIN, peak_mag = 0.
- mem_addr never exceeds END_BIN. No write port; the block never writes memory.
- rst asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: FIND_FREQ_THRESHOLD_EN.
- Defined: in MAP, if peak_mag < MIN_MAG then note=7 and difference=0; otherwise normal mapping.
- Not defined: MIN_MAG is ignored and the nearest note is always reported; note is never 7 after a completed scan.

Test Plan:
- Reset: assert rst mid-scan -> note=7, difference=0, did_find=0, mem_addr=0 immediately.
- Single peak: mem[100]=900, others 5; pulse-hold enable -> did_find after 1026 cycles; note=3, difference=0.
- Offset and tie:
  - mem[130]=700 -> note=4, difference=+4.
  - mem[91]=600 (A2 distance 35 vs G3 distance 9) -> note=3, difference=-9.
  - Equal mags at bins 60 and 200 -> peak_bin=60, note=1, difference=+4.
- Boundaries:
  - Midpoint bin 49 between TGT0=42 and TGT1=56 -> note=0, difference=+7.
  - Peak at END_BIN=1023 -> note=5, difference=+511 (saturated from 854).
- Threshold (macro on): all bins <= 10 -> note=7, difference=0. Macro off: same input -> note=0, difference=-41 (peak_bin=1).
- Handshake: drop enable at cycle 500 -> IDLE, outputs unchanged. Re-raise enable -> full rescan completes; did_find held until enable=0, then low one cycle later.
